// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: lane state encoding and the
// counter-width helper used to size each lane's period counter.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } lane_state_t;

  // Smallest width that holds max(hold, gap) - 1; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int max_load;
    max_load = ((hold > gap) ? hold : gap) - 1;
    return (max_load < 1) ? 1 : $clog2(max_load + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_lane.sv
// One lane of the stretcher: turns single-cycle requests into fixed-width
// high pulses separated by a forced low gap, remembering one extra request.
module pulse_stretch_lane
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic out,
  output logic busy
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  lane_state_t   state;
  logic [CW-1:0] cnt;
  logic          pending;

  // NOTE: every register here, outputs included, is cleared by the async
  // reset so out/busy drop immediately without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      out     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch reads the
      // pre-edge values of state/cnt/pending.
      case (state)
        IDLE: begin
          if (req) begin
            state <= HIGH;
            cnt   <= HOLD_LOAD;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end

        HIGH: begin
          if (req) pending <= 1'b1;
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            out   <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            // A request on the exit edge is consumed directly, not queued.
            if (pending || req) begin
              state   <= HIGH;
              cnt     <= HOLD_LOAD;
              pending <= 1'b0;
              out     <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
            if (req) pending <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pending <= 1'b0;
          out     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Multi-lane pulse stretcher: data_width independent lanes, each stretching
// its request bit into HOLD_CYCLES-wide pulses with a GAP_CYCLES low gap.
module pulse_stretch #(
  parameter int data_width  = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out,
  output logic [data_width-1:0] busy
);

  for (genvar i = 0; i < data_width; i++) begin : g_lane
    pulse_stretch_lane #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .req  (data_in[i]),
      .out  (data_out[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch (8 lanes, hold 4, gap 2): a vector
// table fed through a scoreboard queue, plus hand-written reset sequences.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [7:0] busy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [7:0] exp_busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pulse_stretch #(
    .data_width (8),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .data_out(data_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] din, input logic [7:0] o, input logic [7:0] b);
    vec_t v;
    v.din = din; v.exp_out = o; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  // Drive one vector just after an edge, queue its expectation, compare after the next edge.
  task automatic apply(input int idx);
    vec_t e;
    data_in = vecs[idx].din;
    sb.push_back(vecs[idx]);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d data_out", idx), data_out, e.exp_out);
    check($sformatf("vec%0d busy", idx), busy, e.exp_busy);
  endtask

  initial begin
    // Single pulse on lane 0: 4 high, 2 gap, idle.
    add(8'h01, 8'h01, 8'h01);
    add(8'h00, 8'h01, 8'h01);
    add(8'h00, 8'h01, 8'h01);
    add(8'h00, 8'h01, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    add(8'h00, 8'h00, 8'h00);
    // Pulses at t and t+2: second request becomes one more pulse after the gap.
    add(8'h01, 8'h01, 8'h01);
    add(8'h00, 8'h01, 8'h01);
    add(8'h01, 8'h01, 8'h01);
    add(8'h00, 8'h01, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    for (int k = 0; k < 4; k++) add(8'h00, 8'h01, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    add(8'h00, 8'h00, 8'h01);
    add(8'h00, 8'h00, 8'h00);
    // Three requests in one window on lane 1: exactly two pulses.
    add(8'h02, 8'h02, 8'h02);
    add(8'h00, 8'h02, 8'h02);
    add(8'h02, 8'h02, 8'h02);
    add(8'h00, 8'h02, 8'h02);
    add(8'h00, 8'h00, 8'h02);
    add(8'h02, 8'h00, 8'h02);
    for (int k = 0; k < 4; k++) add(8'h00, 8'h02, 8'h02);
    add(8'h00, 8'h00, 8'h02);
    add(8'h00, 8'h00, 8'h02);
    add(8'h00, 8'h00, 8'h00);
    add(8'h00, 8'h00, 8'h00);
    // Lane 7 held high for 20 cycles: 4 high / 2 low repeating.
    for (int k = 0; k < 20; k++) add(8'h80, ((k % 6) < 4) ? 8'h80 : 8'h00, 8'h80);
    // The request seen mid-HIGH on the last held edge leaves one queued pulse.
    add(8'h00, 8'h80, 8'h80);
    add(8'h00, 8'h80, 8'h80);
    add(8'h00, 8'h00, 8'h80);
    add(8'h00, 8'h00, 8'h80);
    for (int k = 0; k < 4; k++) add(8'h00, 8'h80, 8'h80);
    add(8'h00, 8'h00, 8'h80);
    add(8'h00, 8'h00, 8'h80);
    add(8'h00, 8'h00, 8'h00);
    // Lanes 0 and 3 together; lane 3 re-requests on its GAP exit edge.
    add(8'h09, 8'h09, 8'h09);
    for (int k = 0; k < 3; k++) add(8'h00, 8'h09, 8'h09);
    add(8'h00, 8'h00, 8'h09);
    add(8'h00, 8'h00, 8'h09);
    add(8'h08, 8'h08, 8'h08);
    for (int k = 0; k < 3; k++) add(8'h00, 8'h08, 8'h08);
    add(8'h00, 8'h00, 8'h08);
    add(8'h00, 8'h00, 8'h08);
    add(8'h00, 8'h00, 8'h00);

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("async reset data_out", data_out, 8'h00);
    check("async reset busy", busy, 8'h00);
    // data_in ignored while reset is held across edges.
    data_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset ignores data_in out", data_out, 8'h00);
    check("reset ignores data_in busy", busy, 8'h00);
    data_in = 8'h00;
    reset = 1'b0;

    foreach (vecs[i]) apply(i);
    check("scoreboard drained", 8'(sb.size()), 8'h00);

    // Reset mid-HIGH on all lanes drops outputs between edges.
    data_in = 8'hFF;
    @(posedge clk); #1;
    check("all lanes high", data_out, 8'hFF);
    data_in = 8'hFF;
    @(posedge clk); #1;
    data_in = 8'h00;
    @(posedge clk); #1;
    check("all lanes still high", data_out, 8'hFF);
    #3 reset = 1'b1;
    #1;
    check("mid-HIGH reset data_out", data_out, 8'h00);
    check("mid-HIGH reset busy", busy, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset idle out %0d", k), data_out, 8'h00);
      check($sformatf("post-reset idle busy %0d", k), busy, 8'h00);
    end

    // First request after reset is sampled normally.
    data_in = 8'h10;
    @(posedge clk); #1;
    check("post-reset pulse out", data_out, 8'h10);
    check("post-reset pulse busy", busy, 8'h10);
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset pulse last high", data_out, 8'h10);
    repeat (3) @(posedge clk);
    #1;
    check("post-reset pulse idle busy", busy, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter data_width, default 8: number of independent lanes.
REQ-002 Parameter HOLD_CYCLES, default 4: high time per output pulse in clk cycles; legal range 1 or more.
REQ-003 Parameter GAP_CYCLES, default 2: forced low time after each high period; legal range 1 or more.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port data_in, input, data_width bits: per-lane single-cycle request pulses, synchronous to clk.
REQ-007 Port data_out, output, data_width bits: per-lane stretched level, registered.
REQ-008 Port busy, output, data_width bits: per-lane, high while the lane is not IDLE; registered.

Function
REQ-009 Each lane SHALL operate independently, with its own state, counter and pending flag.
REQ-010 Each lane SHALL have three states: IDLE (out 0), HIGH (out 1) and GAP (out 0); data_out[i] is 1 exactly when lane i is in HIGH.
REQ-011 IDLE with data_in[i]=1 at an edge: go to HIGH, counter = HOLD_CYCLES-1; data_out[i] rises after that edge (latency 1).
REQ-012 HIGH: decrement the counter each edge; at an edge with counter 0, go to GAP, counter = GAP_CYCLES-1.
REQ-013 GAP: decrement the counter each edge; at an edge with counter 0, go to HIGH (counter = HOLD_CYCLES-1, pending cleared) if pending or data_in[i] is 1; otherwise go to IDLE.
REQ-014 data_in[i]=1 while in HIGH or GAP (excluding the GAP exit edge) SHALL set pending; it never extends or restarts the current period.
REQ-015 Pending SHALL saturate at 1: any number of pulses during one HIGH+GAP window yields exactly one further HIGH period.
REQ-016 data_in held high continuously SHALL produce a periodic waveform: HOLD_CYCLES high, GAP_CYCLES low, repeating.
REQ-017 Each output pulse SHALL be exactly HOLD_CYCLES high; consecutive pulses on a lane SHALL be separated by at least GAP_CYCLES low cycles.
REQ-018 Counter width SHALL be the minimum that holds max(HOLD_CYCLES, GAP_CYCLES)-1, with no wrap-around in any state.
REQ-019 busy[i] SHALL be 1 in HIGH and GAP, and 0 in IDLE.
REQ-020 Simultaneous pulses on several lanes SHALL be handled with no cross-lane interaction.

Reset
REQ-021 While reset=1, every lane SHALL be IDLE, with counter 0 and pending 0; data_out and busy are all zero, asynchronously, with no clock needed.
REQ-022 Reset asserted mid-HIGH or mid-GAP SHALL drop data_out within the same cycle and discard pending requests.
REQ-023 data_in SHALL be ignored while reset=1; the first edge after deassertion samples data_in normally.

Structure
REQ-024 A shared package SHALL hold the lane state encoding constants (IDLE, HIGH, GAP) and the counter-width function.
REQ-025 One sub-module, pulse_stretch_lane, SHALL implement a single lane; the top instantiates data_width copies through a generate loop.
REQ-026 No combinational path SHALL exist from data_in to data_out or busy.

Verification (data_width=8, HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-027 Single pulse data_in=0x01 for 1 cycle at edge t -> data_out[0] high for edges t..t+3, low from t+4; busy[0] low from t+6.
REQ-028 Pulses 0x01 at t and t+2 -> first pulse 4 high, 2 low, second pulse 4 high, then IDLE; no extension of the first pulse.
REQ-029 Three pulses inside one HIGH+GAP window -> exactly two output pulses in total (pending saturation).
REQ-030 data_in=0x80 held constant for 20 cycles -> data_out[7] pattern 4 high / 2 low repeating; other bits stay 0.
REQ-031 data_in=0xFF pulse, then reset asserted 2 cycles later between edges -> data_out=0x00 immediately; after release with no input, outputs stay 0.
REQ-032 Pulse at the GAP exit edge (GAP counter 0) on lane 3 -> HIGH re-entered on that edge with no IDLE cycle; lanes 0-2 are unaffected.
